// File: rtl/fmd_pkg.sv
// fmd_pkg: shared indices and constants for the FP mul/div output stage
package fmd_pkg;
    localparam int DP_EXP_W  = 11;
    localparam int DP_FRAC_W = 52;
    localparam int FLQ_DBZ  = 0;
    localparam int FLQ_INV  = 1;
    localparam int FLQ_NAN  = 2;
    localparam int FLQ_INF  = 3;
    localparam int FLQ_ZERO = 4;
    localparam int EXC_INX = 0;
    localparam int EXC_UNF = 1;
    localparam int EXC_OVF = 2;
    localparam int EXC_DBZ = 3;
    localparam int EXC_INV = 4;
    localparam logic [DP_EXP_W-1:0] EXP_ONES = '1;
    localparam int QNAN_BIT = DP_FRAC_W - 1;
    typedef logic [4:0] exc_t;
endpackage

// File: rtl/fmd_pipe_stage.sv
// fmd_pipe_stage: one-deep valid/ready register slice
module fmd_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);
    logic         valid_q;
    logic [W-1:0] data_q;

    assign ready_o = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (ready_o) begin
            valid_q <= valid_i;
            if (valid_i) data_q <= data_i;
        end
    end
endmodule

// File: rtl/fmd_spec_pack.sv
// fmd_spec_pack: special-case result select, exception vector and sticky flags
module fmd_spec_pack
    import fmd_pkg::*;
#(
    parameter int EXP_W  = DP_EXP_W,
    parameter int FRAC_W = DP_FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FRAC_W+5:0]       flq,
    input  logic                    sq,
    input  logic [EXP_W+FRAC_W:0]   rnd_res,
    input  logic [2:0]              rnd_exc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   fp_out,
    output exc_t                    exc,
    input  logic                    sticky_clr,
    output exc_t                    sticky_flags
);
    localparam int FW = FRAC_W + 6;
    localparam int RW = 1 + EXP_W + FRAC_W;
    localparam int W1 = FW + RW + 4;
    localparam int W2 = RW + 5;

    logic          s1_valid, s2_ready;
    logic [W1-1:0] s1_data;
    logic [W2-1:0] s2_data;
    logic [FW-1:0] f;
    logic          s, special;
    logic [RW-1:0] r, res_d;
    logic [2:0]    re;
    exc_t          exc_d, sticky_q, sticky_d;

    fmd_pipe_stage #(.W(W1)) u_s1 (
        .clk(clk), .rst(rst),
        .valid_i(in_valid), .ready_o(in_ready), .data_i({flq, sq, rnd_res, rnd_exc}),
        .valid_o(s1_valid), .ready_i(s2_ready), .data_o(s1_data)
    );

    assign {f, s, r, re} = s1_data;
    assign special = f[FLQ_NAN] | f[FLQ_INF] | f[FLQ_ZERO];

    // NaN payload keeps its sign and fraction but is always made quiet
    always_comb begin
        res_d = f[FLQ_NAN]  ? {f[FW-1], EXP_ONES, f[FW-2:5] | (FRAC_W'(1) << QNAN_BIT)} :
                f[FLQ_INF]  ? {s, EXP_ONES, {FRAC_W{1'b0}}} :
                f[FLQ_ZERO] ? {s, {(RW-1){1'b0}}} : r;
        exc_d = '0;
        exc_d[EXC_INV] = special & f[FLQ_INV];
        exc_d[EXC_DBZ] = special & f[FLQ_DBZ];
        exc_d[EXC_OVF] = ~special & re[2];
        exc_d[EXC_UNF] = ~special & re[1];
        exc_d[EXC_INX] = ~special & re[0];
    end

    fmd_pipe_stage #(.W(W2)) u_s2 (
        .clk(clk), .rst(rst),
        .valid_i(s1_valid), .ready_o(s2_ready), .data_i({res_d, exc_d}),
        .valid_o(out_valid), .ready_i(out_ready), .data_o(s2_data)
    );

    assign {fp_out, exc} = s2_data;

    // clear and accumulate in the same cycle leave only the delivered result's flags
    assign sticky_d = (sticky_clr ? '0 : sticky_q) | ((out_valid & out_ready) ? exc : '0);
    assign sticky_flags = sticky_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sticky_q <= '0;
        else     sticky_q <= sticky_d;
    end
endmodule
